// File: rtl/edge_event_arbiter.sv
// Synchronises NUM_CH asynchronous status lines, latches enabled edges as timestamped
// pending events and serialises them round-robin onto one valid/ready stream.
module edge_event_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TS_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             in_lines,
  input  logic [NUM_CH-1:0]             rise_en,
  input  logic [NUM_CH-1:0]             fall_en,
  input  logic                          clear_ovf,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [$clog2(NUM_CH)-1:0]     evt_ch,
  output logic                          evt_rising,
  output logic [TS_WIDTH-1:0]           evt_ts,
  output logic [NUM_CH-1:0]             ovf,
  output logic                          busy
);

  localparam int CHW   = $clog2(NUM_CH);
  localparam int ARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

  typedef enum logic {EMPTY, FULL} state_t;

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_p0;
  logic [NUM_CH-1:0]   prev_p1;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [ARM_W-1:0]    arm_cnt;
  logic                armed;
  logic [NUM_CH-1:0]   sync_s, rise_det, fall_det, edge_det;
  logic [NUM_CH-1:0]   pend, pend_rise, slot_load, ovf_set, grant_vec;
  logic [TS_WIDTH-1:0] pend_ts [NUM_CH];
  logic [CHW-1:0]      last_grant, gnt_idx, cand_idx;
  logic                gnt_found, take;
  state_t              state_q, state_d;

  // Stage 0/1: synchroniser chain and previous-value register
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      prev_p1 <= '0;
      ts_cnt  <= '0;
      arm_cnt <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], in_lines};
      prev_p1 <= sync_p0[SYNC_STAGES-1];
      ts_cnt  <= ts_cnt + TS_WIDTH'(1);
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  // Detection is held off until the chain has flushed post-reset contents.
  assign armed    = (arm_cnt == ARM_DONE);
  assign sync_s   = sync_p0[SYNC_STAGES-1];
  assign rise_det = sync_s & ~prev_p1 & rise_en & {NUM_CH{armed}};
  assign fall_det = ~sync_s & prev_p1 & fall_en & {NUM_CH{armed}};
  assign edge_det = rise_det | fall_det;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand_idx = CHW'((int'(last_grant) + i) % NUM_CH);
      if (!gnt_found && pend[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    grant_vec = '0;
    if (state_q == EMPTY || evt_ready) begin
      state_d = gnt_found ? FULL : EMPTY;
      take    = gnt_found;
    end
    if (take) grant_vec[gnt_idx] = 1'b1;
  end

  // A slot being granted this cycle is free to take a new edge without overflow.
  assign slot_load = edge_det & (~pend | grant_vec);
  assign ovf_set   = edge_det & pend & ~grant_vec;

  // Stage 2: pending slots
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~grant_vec) | slot_load;
  end

  always_ff @(posedge clk) begin
    pend_rise <= (pend_rise & ~slot_load) | (rise_det & slot_load);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    always_ff @(posedge clk) begin
      if (slot_load[g]) pend_ts[g] <= ts_cnt;
    end
  end

  // Stage 3: output register and overflow flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      last_grant <= CHW'(NUM_CH - 1);
      evt_ch     <= '0;
      evt_rising <= 1'b0;
      evt_ts     <= '0;
      ovf        <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        evt_ch     <= gnt_idx;
        evt_rising <= pend_rise[gnt_idx];
        evt_ts     <= pend_ts[gnt_idx];
        last_grant <= gnt_idx;
      end
      ovf <= (ovf & ~{NUM_CH{clear_ovf}}) | ovf_set;
    end
  end

  assign evt_valid = (state_q == FULL);
  assign busy      = (|pend) | evt_valid;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a delay-line/queue model.
module tb_edge_event_arbiter;

  localparam int NUM_CH = 4;
  localparam int S      = 2;
  localparam int TSW    = 16;
  localparam int CHW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NUM_CH-1:0] in_lines = '0;
  logic [NUM_CH-1:0] rise_en = '0;
  logic [NUM_CH-1:0] fall_en = '0;
  logic              clear_ovf = 1'b0;
  logic              evt_ready = 1'b1;
  logic              evt_valid;
  logic [CHW-1:0]    evt_ch;
  logic              evt_rising;
  logic [TSW-1:0]    evt_ts;
  logic [NUM_CH-1:0] ovf;
  logic              busy;

  edge_event_arbiter #(.NUM_CH(NUM_CH), .SYNC_STAGES(S), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rst(rst), .in_lines(in_lines), .rise_en(rise_en), .fall_en(fall_en),
    .clear_ovf(clear_ovf), .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_rising(evt_rising), .evt_ts(evt_ts), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: history of sampled lines, plain slot arrays, round-robin search.
  logic [NUM_CH-1:0] hist [S+1];
  int                m_cnt;
  logic [TSW-1:0]    m_ts;
  logic [NUM_CH-1:0] m_pend, m_pend_rise, m_ovf;
  logic [TSW-1:0]    m_pend_ts [NUM_CH];
  bit                m_valid;
  logic [CHW-1:0]    m_ch;
  logic              m_rise;
  logic [TSW-1:0]    m_evt_ts;
  int                m_last;
  bit                started = 1'b0;

  always @(posedge clk) begin : model_step
    logic [NUM_CH-1:0] s_now, p_now;
    logic [CHW-1:0]    ci;
    bit                armed_m, found, r, f;
    if (rst) begin
      for (int j = 0; j <= S; j++) hist[j] = '0;
      m_cnt = 0; m_ts = '0; m_pend = '0; m_pend_rise = '0; m_ovf = '0;
      m_valid = 1'b0; m_ch = '0; m_rise = 1'b0; m_evt_ts = '0;
      m_last = NUM_CH - 1;
      started = 1'b1;
    end else begin
      s_now   = hist[S-1];
      p_now   = hist[S];
      armed_m = (m_cnt >= S + 1);
      if (!m_valid || evt_ready) begin
        found = 1'b0;
        for (int k = 1; k <= NUM_CH; k++) begin
          ci = CHW'((m_last + k) % NUM_CH);
          if (!found && m_pend[ci]) begin
            found = 1'b1;
            m_ch = ci; m_rise = m_pend_rise[ci]; m_evt_ts = m_pend_ts[ci];
            m_pend[ci] = 1'b0;
            m_last = int'(ci);
          end
        end
        m_valid = found;
      end
      if (clear_ovf) m_ovf = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        ci = CHW'(k);
        r = armed_m && s_now[ci] && !p_now[ci] && rise_en[ci];
        f = armed_m && !s_now[ci] && p_now[ci] && fall_en[ci];
        if (r || f) begin
          if (!m_pend[ci]) begin
            m_pend[ci] = 1'b1; m_pend_rise[ci] = r; m_pend_ts[ci] = m_ts;
          end else begin
            m_ovf[ci] = 1'b1;
          end
        end
      end
      for (int j = S; j >= 1; j--) hist[j] = hist[j-1];
      hist[0] = in_lines;
      m_ts = m_ts + TSW'(1);
      if (m_cnt < 1000) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(evt_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'((|m_pend) || m_valid));
      chk("ovf", 32'(ovf), 32'(m_ovf));
      if (m_valid) begin
        chk("ch", 32'(evt_ch), 32'(m_ch));
        chk("rising", 32'(evt_rising), 32'(m_rise));
        chk("ts", 32'(evt_ts), 32'(m_evt_ts));
      end
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (evt_valid === 1'b1) return;
    end
    chk({name, "_timeout"}, 32'(evt_valid), 32'd1);
  endtask

  initial begin
    // 1: single rising edge on ch2
    rise_en = '1;
    reset_dut();
    repeat (5) @(posedge clk);
    #1 in_lines[2] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_not_yet", 32'(evt_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid", 32'(evt_valid), 32'd1);
    chk("t1_ch", 32'(evt_ch), 32'd2);
    chk("t1_rising", 32'(evt_rising), 32'd1);
    chk("t1_ts", 32'(evt_ts), 32'd7);

    // 2: lines high through reset, then falling edge on ch0
    in_lines = '1; fall_en = 4'b0001;
    reset_dut();
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t2_quiet_valid", 32'(evt_valid), 32'd0);
    chk("t2_quiet_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 in_lines[0] = 1'b0;
    wait_valid("t2", 10);
    chk("t2_ch", 32'(evt_ch), 32'd0);
    chk("t2_rising", 32'(evt_rising), 32'd0);

    // 3: simultaneous rising edges on all channels
    in_lines = '0; fall_en = '0;
    reset_dut();
    repeat (5) @(posedge clk);
    #1 in_lines = '1;
    wait_valid("t3", 10);
    for (int k = 0; k < 4; k++) begin
      chk("t3_seq_ch", 32'(evt_ch), 32'(k));
      chk("t3_seq_ts", 32'(evt_ts), 32'd7);
      @(negedge clk);
    end
    chk("t3_drained", 32'(evt_valid), 32'd0);

    // 4: back-pressure, slot fill, overflow, clear
    in_lines = '0; fall_en = '1; evt_ready = 1'b0;
    reset_dut();
    repeat (5) @(posedge clk);
    #1 in_lines[1] = 1'b1;
    wait_valid("t4", 10);
    chk("t4_first_ts", 32'(evt_ts), 32'd7);
    @(posedge clk);
    #1 in_lines[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 in_lines[1] = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t4_hold_ch", 32'(evt_ch), 32'd1);
    chk("t4_hold_rising", 32'(evt_rising), 32'd1);
    chk("t4_hold_ts", 32'(evt_ts), 32'd7);
    chk("t4_ovf", 32'(ovf), 32'h2);
    @(posedge clk);
    #1 clear_ovf = 1'b1;
    @(posedge clk);
    #1 clear_ovf = 1'b0;
    @(negedge clk);
    chk("t4_ovf_clear", 32'(ovf), 32'h0);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("t4_second_ch", 32'(evt_ch), 32'd1);
    chk("t4_second_rising", 32'(evt_rising), 32'd0);
    chk("t4_second_ts", 32'(evt_ts), 32'd12);

    // 5: timestamp wrap
    in_lines = '0; fall_en = '0;
    reset_dut();
    repeat (65533) @(posedge clk);
    #1 in_lines[0] = 1'b1;
    @(posedge clk);
    #1 in_lines[1] = 1'b1;
    wait_valid("t5", 10);
    chk("t5_ch_a", 32'(evt_ch), 32'd0);
    chk("t5_ts_a", 32'(evt_ts), 32'h0000FFFF);
    @(negedge clk);
    chk("t5_valid_b", 32'(evt_valid), 32'd1);
    chk("t5_ch_b", 32'(evt_ch), 32'd1);
    chk("t5_ts_b", 32'(evt_ts), 32'h00000000);

    // 6: reset with a held event and two pending
    in_lines = '0; evt_ready = 1'b0;
    reset_dut();
    repeat (5) @(posedge clk);
    #1 in_lines = 4'b0111;
    wait_valid("t6", 10);
    @(negedge clk);
    chk("t6_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(evt_valid), 32'd0);
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_stale", 32'(evt_valid), 32'd0);

    // randomized traffic
    in_lines = '0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 2) == 0) in_lines = NUM_CH'($urandom);
      if ($urandom_range(0, 63) == 0) rise_en = NUM_CH'($urandom);
      if ($urandom_range(0, 63) == 0) fall_en = NUM_CH'($urandom);
      evt_ready = ($urandom_range(0, 3) != 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      rst       = ($urandom_range(0, 249) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0; clear_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
